// File: rtl/rr_mux_arbiter_if.sv
// rr_mux_arbiter_if: requester/stream bundle for the round-robin mux arbiter.
// master = requester/consumer side, slave = arbiter side.
interface rr_mux_arbiter_if #(
    parameter int DATA_W = 8
);
    logic [3:0]          req;
    logic [4*DATA_W-1:0] data_in;
    logic [3:0]          gnt;
    logic [1:0]          sel;
    logic                busy;
    logic                out_valid;
    logic [DATA_W-1:0]   out_data;
    logic                out_ready;

    modport master (
        output req, data_in, out_ready,
        input  gnt, sel, busy, out_valid, out_data
    );

    modport slave (
        input  req, data_in, out_ready,
        output gnt, sel, busy, out_valid, out_data
    );
endinterface

// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin grant of a shared 4:1 mux with bounded bursts.
// One idle cycle separates grants; sel holds its last value after release.
module rr_mux_arbiter #(
    parameter int DATA_W    = 8,
    parameter int BURST_LEN = 4
) (
    input logic          clk,
    input logic          rst_n,
    rr_mux_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] ptr_q, ptr_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] win;
    logic       busy;
    logic       valid;
    logic       xfer;
    logic       last;

    assign busy  = (state_q == BUSY);
    assign valid = busy & bus.req[sel_q];
    assign xfer  = valid & bus.out_ready;
    assign last  = (cnt_q == 8'(BURST_LEN - 1));

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.busy      = busy;
    assign bus.out_valid = valid;
    assign bus.out_data  = busy ? bus.data_in[sel_q*DATA_W +: DATA_W]
                                : '0;

    // Winner: first set request scanning from ptr upward, wrapping mod 4.
    always_comb begin
        win = ptr_q;
        for (int i = 3; i >= 0; i--) begin
            if (bus.req[ptr_q + 2'(i)]) begin
                win = ptr_q + 2'(i);
            end
        end
    end

    // State register; reset aborts any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: arbitrate in IDLE, count beats and release in BUSY.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d = BUSY;
                    gnt_d   = 4'b0001 << win;
                    sel_d   = win;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if ((xfer && last) || !bus.req[sel_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    cnt_d   = '0;
                    ptr_d   = sel_q + 2'd1;
                end else if (xfer) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end
endmodule
